dma_priority_arbiter: RTL and testbench

Channel priority and bus-handshake sequencer for the 8237A-5 DMA controller. It merges the hardware DREQ lines, the software request register and the mask register into one effective request per channel. It selects a winner under fixed or rotating priority, then runs the HRQ/HLDA handshake with the CPU. It drives DACK for the granted channel until the timing/control block reports the service complete.

---
 rtl/dma_priority_arbiter.sv | 153 +++++++++++++++
 tb/tb_dma_priority_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter
// Channel priority and HRQ/HLDA handshake sequencer for an 8237A-5 style DMA
// controller. Merges DREQ, software requests and mask into one effective
// request per channel and picks a winner under fixed or rotating priority. It
// then raises HRQ, waits for HLDA, and drives DACK for the granted channel
// until SvcDone ends the service.
//
// Ports:
//   CLK, RESET       clock; synchronous active-high reset
//   DREQ, SwReq      hardware (polarity per DREQsense) and software requests
//   Mask             1 blocks the hardware DREQ of that channel
//   DREQsense        0 = DREQ active-high, 1 = active-low
//   DACKsense        0 = DACK active-low, 1 = active-high
//   FRpriority       0 = fixed priority (ch0 highest), 1 = rotating priority
//   ContrDis         1 = no new requests are started
//   HLDA, SvcDone    CPU hold acknowledge; end-of-service pulse
//   HRQ              hold request to the CPU
//   DACK             one-hot acknowledge while serving, polarity per DACKsense
//   ChGrant          index of the latched winner
//   GrantValid       1 while serving
module dma_priority_arbiter #(
  parameter int unsigned NumChannels = 4
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [NumChannels-1:0]         DREQ,
  input  logic [NumChannels-1:0]         SwReq,
  input  logic [NumChannels-1:0]         Mask,
  input  logic                           DREQsense,
  input  logic                           DACKsense,
  input  logic                           FRpriority,
  input  logic                           ContrDis,
  input  logic                           HLDA,
  input  logic                           SvcDone,
  output logic                           HRQ,
  output logic [NumChannels-1:0]         DACK,
  output logic [$clog2(NumChannels)-1:0] ChGrant,
  output logic                           GrantValid
);

  // Cyclic priority wraps via index-width overflow, so NumChannels must be a power of two.
  localparam int unsigned ChIdxW = $clog2(NumChannels);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVE   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                   state, state_n;
  logic                     hrq_n;
  logic [NumChannels-1:0]   dack_oh, dack_oh_n;
  logic [ChIdxW-1:0]        grant_n;
  logic                     gv_n;
  logic [ChIdxW-1:0]        last_served, last_served_n;

  logic [NumChannels-1:0]   eff;
  logic [ChIdxW-1:0]        winner;
  logic [ChIdxW-1:0]        base;
  logic [ChIdxW-1:0]        idx;
  logic                     found;

  // Effective request per channel; software requests bypass the mask.
  assign eff = ((DREQ ^ {NumChannels{DREQsense}}) & ~Mask) | SwReq;

  // Winner search starting at channel 0 (fixed) or one past the last served (rotating).
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    base   = FRpriority ? ChIdxW'(last_served + ChIdxW'(1)) : '0;
    for (int k = 0; k < int'(NumChannels); k++) begin
      idx = ChIdxW'(base + ChIdxW'(k));
      if (!found && eff[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= S_IDLE;
      HRQ         <= 1'b0;
      dack_oh     <= '0;
      ChGrant     <= '0;
      GrantValid  <= 1'b0;
      last_served <= ChIdxW'(NumChannels - 1);
    end else begin
      state       <= state_n;
      HRQ         <= hrq_n;
      dack_oh     <= dack_oh_n;
      ChGrant     <= grant_n;
      GrantValid  <= gv_n;
      last_served <= last_served_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n       = state;
    hrq_n         = HRQ;
    dack_oh_n     = dack_oh;
    grant_n       = ChGrant;
    gv_n          = GrantValid;
    last_served_n = last_served;

    unique case (state)
      S_IDLE: begin
        if (!ContrDis && found) begin
          grant_n = winner;
          hrq_n   = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        // The latched winner is kept even if a higher-priority request shows up.
        if (HLDA) begin
          dack_oh_n = NumChannels'(1) << ChGrant;
          gv_n      = 1'b1;
          state_n   = S_SERVE;
        end else if (!eff[ChGrant] || ContrDis) begin
          hrq_n   = 1'b0;
          state_n = S_IDLE;
        end
      end
      S_SERVE: begin
        // Completion and abort look the same on the bus; only completion rotates priority.
        if (SvcDone || !HLDA) begin
          hrq_n     = 1'b0;
          dack_oh_n = '0;
          gv_n      = 1'b0;
          state_n   = S_RELEASE;
          if (SvcDone) begin
            last_served_n = ChGrant;
          end
        end
      end
      S_RELEASE: begin
        if (!HLDA) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Only the polarity select is combinational on the output path.
  assign DACK = DACKsense ? dack_oh : ~dack_oh;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
module tb_dma_priority_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] dreq, sw_req, mask;
  logic       dreq_sense, dack_sense, fr_priority, contr_dis, hlda, svc_done;
  logic       HRQ, GrantValid;
  logic [3:0] DACK;
  logic [1:0] ChGrant;

  int total = 0;
  int bad   = 0;

  // Reference model: transaction phase, who holds the grant, who was last served.
  localparam int PH_IDLE  = 0;
  localparam int PH_WAIT  = 1;
  localparam int PH_SERVE = 2;
  localparam int PH_REL   = 3;
  int m_phase, m_grant, m_last;
  bit m_hrq, m_gv;

  always #5 clk = ~clk;

  dma_priority_arbiter #(.NumChannels(4)) dut (
    .CLK(clk), .RESET(reset), .DREQ(dreq), .SwReq(sw_req), .Mask(mask),
    .DREQsense(dreq_sense), .DACKsense(dack_sense), .FRpriority(fr_priority),
    .ContrDis(contr_dis), .HLDA(hlda), .SvcDone(svc_done),
    .HRQ(HRQ), .DACK(DACK), .ChGrant(ChGrant), .GrantValid(GrantValid)
  );

  function automatic bit eff_bit(int ch);
    bit raw;
    raw = dreq[ch] ^ dreq_sense;
    return (raw && !mask[ch]) || sw_req[ch];
  endfunction

  function automatic int pick_winner(bit rot, int last);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = rot ? (last + 1 + k) % 4 : k;
      if (eff_bit(c)) return c;
    end
    return -1;
  endfunction

  task automatic model_update();
    int w;
    if (reset) begin
      m_phase = PH_IDLE; m_hrq = 0; m_gv = 0; m_grant = 0; m_last = 3;
      return;
    end
    if (m_phase == PH_IDLE) begin
      w = pick_winner(fr_priority, m_last);
      if (!contr_dis && w >= 0) begin
        m_grant = w; m_hrq = 1; m_phase = PH_WAIT;
      end
    end else if (m_phase == PH_WAIT) begin
      if (hlda) begin
        m_gv = 1; m_phase = PH_SERVE;
      end else if (!eff_bit(m_grant) || contr_dis) begin
        m_hrq = 0; m_phase = PH_IDLE;
      end
    end else if (m_phase == PH_SERVE) begin
      if (svc_done || !hlda) begin
        if (svc_done) m_last = m_grant;
        m_hrq = 0; m_gv = 0; m_phase = PH_REL;
      end
    end else begin
      if (!hlda) m_phase = PH_IDLE;
    end
  endtask

  function automatic logic [3:0] exp_dack();
    logic [3:0] oh;
    oh = m_gv ? 4'(1 << m_grant) : 4'b0000;
    return dack_sense ? oh : ~oh;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model on the edge, then compare all outputs.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("hrq",   32'(HRQ),        32'(m_hrq));
    chk("grant", 32'(ChGrant),    32'(m_grant));
    chk("gv",    32'(GrantValid), 32'(m_gv));
    chk("dack",  32'(DACK),       32'(exp_dack()));
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1; dreq = 0; sw_req = 0; mask = 0; dreq_sense = 0; dack_sense = 0;
    fr_priority = 0; contr_dis = 0; hlda = 0; svc_done = 0;
    m_phase = PH_IDLE; m_hrq = 0; m_gv = 0; m_grant = 0; m_last = 3;
    tick(2);
    chk("rst_dack", 32'(DACK), 32'h0000000f);
    chk("rst_hrq", 32'(HRQ), 32'h0);
    reset = 0;

    // Fixed priority: DREQ 1010 -> channel 1, DACK 1101 for exactly 3 cycles.
    dreq = 4'b1010;
    tick(1);
    chk("fix_hrq", 32'(HRQ), 32'h1);
    chk("fix_grant", 32'(ChGrant), 32'h1);
    tick(1);
    hlda = 1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("fix_dack_on", 32'(DACK), 32'hd);
      if (i == 2) svc_done = 1;
    end
    tick(1);
    chk("fix_dack_off", 32'(DACK), 32'hf);
    chk("fix_hrq_drop", 32'(HRQ), 32'h0);
    svc_done = 0; dreq = 0; hlda = 0;
    tick(1);

    // Rotating priority from reset: grants 0,1,2,3,0.
    reset = 1; tick(1); reset = 0;
    fr_priority = 1; dreq = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("rot_hrq", 32'(HRQ), 32'h1);
      chk("rot_grant", 32'(ChGrant), 32'(i % 4));
      hlda = 1; tick(1);
      svc_done = 1; tick(1);
      svc_done = 0; hlda = 0; tick(1);
    end

    // Mask blocks hardware requests; software request is never masked.
    mask = 4'b1111; fr_priority = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("mask_hrq", 32'(HRQ), 32'h0);
    end
    sw_req = 4'b0100;
    tick(1);
    chk("sw_hrq", 32'(HRQ), 32'h1);
    chk("sw_grant", 32'(ChGrant), 32'h2);
    hlda = 1; tick(1);
    svc_done = 1; tick(1);
    svc_done = 0; hlda = 0; sw_req = 0; tick(1);

    // Request withdrawn before HLDA, then controller disabled.
    mask = 0; dreq = 4'b1000;
    tick(1);
    chk("wd_grant", 32'(ChGrant), 32'h3);
    dreq = 0;
    tick(1);
    chk("wd_hrq", 32'(HRQ), 32'h0);
    chk("wd_dack", 32'(DACK), 32'hf);
    contr_dis = 1; dreq = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("dis_hrq", 32'(HRQ), 32'h0);
    end
    contr_dis = 0; dreq = 0; tick(1);

    // Abort with inverted polarities, then reset in the middle of a service.
    reset = 1; tick(1); reset = 0;
    dack_sense = 1; dreq_sense = 1; fr_priority = 1; dreq = 4'b1110;
    tick(1);
    chk("ab_grant", 32'(ChGrant), 32'h0);
    hlda = 1; tick(1);
    chk("ab_dack_on", 32'(DACK), 32'h1);
    hlda = 0; tick(1);
    chk("ab_dack_off", 32'(DACK), 32'h0);
    chk("ab_hrq", 32'(HRQ), 32'h0);
    tick(2);
    chk("ab_regrant", 32'(ChGrant), 32'h0);
    chk("ab_rehrq", 32'(HRQ), 32'h1);
    hlda = 1; tick(1);
    chk("ab_serve", 32'(GrantValid), 32'h1);
    reset = 1; tick(1);
    chk("mrst_hrq", 32'(HRQ), 32'h0);
    chk("mrst_dack", 32'(DACK), 32'h0);
    chk("mrst_gv", 32'(GrantValid), 32'h0);
    chk("mrst_grant", 32'(ChGrant), 32'h0);
    reset = 0; hlda = 0; dreq = 4'b1111;

    // Randomized traffic with a CPU that usually grants hold and sometimes aborts.
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      dreq = 4'($urandom);
      if ($urandom_range(0, 3) == 0) mask = 4'($urandom);
      sw_req = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 49) == 0) dreq_sense = ~dreq_sense;
      if ($urandom_range(0, 49) == 0) dack_sense = ~dack_sense;
      if ($urandom_range(0, 49) == 0) fr_priority = ~fr_priority;
      contr_dis = ($urandom_range(0, 15) == 0);
      if (m_hrq) begin
        if ($urandom_range(0, 2) != 0) hlda = 1;
      end else begin
        if ($urandom_range(0, 2) != 0) hlda = 0;
      end
      if (m_phase == PH_SERVE && $urandom_range(0, 15) == 0) hlda = 0;
      svc_done = (m_phase == PH_SERVE) && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
